// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM bus arbiter: FSM states and the
// device-select / device-address split of the flat PSRAM address.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } psram_arb_state_e;

  localparam int PSRAM_DEV_NUM    = 4;
  localparam int PSRAM_NSS_W      = 2;
  localparam int PSRAM_DEV_ADDR_W = 23;

endpackage

// File: rtl/psram_rr_arb.sv
// Combinational round-robin picker: first valid requester after the last
// granted index, wrapping. The pointer itself lives in the parent.
module psram_rr_arb #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int k;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      k = (int'(last_i) + off) % NUM_REQ;
      if (!any_o && valid_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/psram_bus_arb.sv
// Serialises word requests from several masters onto one QSPI PSRAM
// controller with round-robin fairness, CS-high gap and WAIT timeout.
module psram_bus_arb
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 32,
  parameter int CS_GAP_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              psram_valid_o,
  input  logic                              psram_ready_i,
  output logic [1:0]                        psram_nss_sel_o,
  output logic [22:0]                       psram_addr_o,
  output logic                              psram_we_o,
  output logic [DATA_WIDTH-1:0]             psram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           psram_wstrb_o,
  input  logic                              psram_done_i,
  input  logic [DATA_WIDTH-1:0]             psram_rdata_i,
  output logic                              psram_abort_o,
  output logic                              busy_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W  = (CS_GAP_CYC > 1) ? $clog2(CS_GAP_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP_CYC > 0) ? CS_GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  psram_arb_state_e state_q, state_d;
  logic [IDX_W-1:0]            last_gnt_q, last_gnt_d;
  logic [PSRAM_NSS_W-1:0]      nss_q, nss_d;
  logic [PSRAM_DEV_ADDR_W-1:0] addr_q, addr_d;
  logic                        we_q, we_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]           wstrb_q, wstrb_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;
  logic                  wait_exit;

  psram_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .valid_i (req_valid_i),
    .last_i  (last_gnt_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we    = req_we_i[i];
        sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = req_wstrb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    nss_d         = nss_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    req_ready_o   = '0;
    psram_valid_o = 1'b0;
    psram_abort_o = 1'b0;
    wait_exit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready_o = arb_gnt;
          last_gnt_d  = arb_idx;
          nss_d       = sel_addr[PSRAM_NSS_W+PSRAM_DEV_ADDR_W-1:PSRAM_DEV_ADDR_W];
          addr_d      = sel_addr[PSRAM_DEV_ADDR_W-1:0];
          we_d        = sel_we;
          wdata_d     = sel_wdata;
          wstrb_d     = sel_wstrb;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        psram_valid_o = 1'b1;
        if (psram_ready_i) begin
          to_cnt_d = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // Completion takes precedence over a timeout landing on the same cycle.
        if (psram_done_i) begin
          wait_exit   = 1'b1;
          rsp_rdata_d = we_q ? '0 : psram_rdata_i;
        end else if (to_cnt_q == TO_LAST) begin
          wait_exit     = 1'b1;
          psram_abort_o = 1'b1;
          rsp_err_d     = 1'b1;
        end
        if (wait_exit) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = (last_gnt_q == IDX_W'(i));
          end
          gap_cnt_d = '0;
          state_d   = (CS_GAP_CYC == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      last_gnt_q  <= LAST_RST;
      nss_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      nss_q       <= nss_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;
  assign psram_nss_sel_o = nss_q;
  assign psram_addr_o    = addr_q;
  assign psram_we_o      = we_q;
  assign psram_wdata_o   = wdata_q;
  assign psram_wstrb_o   = wstrb_q;
  assign busy_o          = (state_q != IDLE);

endmodule
